adc_capture_sequencer: RTL and testbench



---
 rtl/adc_capture_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sequencer.sv
// ---------------------------------------------------------------------------
// adc_capture_sequencer
//
// Purpose: the capture controller that sits between the RFDC ADC AXI4-Stream
// outputs and the capture-buffer AXI4-Stream inputs. An arm request latches
// the configuration. A hardware or software trigger then starts an optional
// holdoff. After the holdoff, the block routes one selected ADC channel into
// each buffer for a programmed number of beats. Everything runs on aclk.
//
// Optional feature: define CAPTURE_TLAST_EN to add m_buf_tlast. It marks the
// final beat of a capture on every buffer.
//
// Ports:
//   aclk, aresetn          stream clock, asynchronous active-low reset
//   arm_i                  single-cycle arm request (honoured in IDLE only)
//   trig_i, sw_trig_i      hardware / software trigger (honoured in ARMED)
//   abort_i                abort the current sequence (highest priority)
//   sel_i                  per-buffer ADC select, buffer b at [b*SEL_WIDTH +: SEL_WIDTH]
//   len_i                  capture length in beats (0 = arm ignored)
//   holdoff_i              cycles between trigger and capture start
//   s_adc_t*               ADC streams in; tready is tied high
//   m_buf_t*               buffer streams out; one cycle of latency, never held
//   armed_o, busy_o        state flags (ARMED / HOLDOFF or CAPTURE)
//   done_o                 last capture completed; held until the next accepted arm
//   overflow_o             sticky; a buffer was not ready for a valid beat
//   beat_count_o           beats accepted in the current or last capture
// ---------------------------------------------------------------------------
module adc_capture_sequencer #(
    parameter int unsigned NUM_ADC       = 8,
    parameter int unsigned NUM_BUF       = 4,
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned SEL_WIDTH     = 3,
    parameter int unsigned LEN_WIDTH     = 16,
    parameter int unsigned HOLDOFF_WIDTH = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          arm_i,
    input  logic                          trig_i,
    input  logic                          sw_trig_i,
    input  logic                          abort_i,
    input  logic [NUM_BUF*SEL_WIDTH-1:0]  sel_i,
    input  logic [LEN_WIDTH-1:0]          len_i,
    input  logic [HOLDOFF_WIDTH-1:0]      holdoff_i,
    input  logic [NUM_ADC*DATA_WIDTH-1:0] s_adc_tdata,
    input  logic [NUM_ADC-1:0]            s_adc_tvalid,
    output logic [NUM_ADC-1:0]            s_adc_tready,
    output logic [NUM_BUF*DATA_WIDTH-1:0] m_buf_tdata,
    output logic [NUM_BUF-1:0]            m_buf_tvalid,
    input  logic [NUM_BUF-1:0]            m_buf_tready,
`ifdef CAPTURE_TLAST_EN
    output logic [NUM_BUF-1:0]            m_buf_tlast,
`endif
    output logic                          armed_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o,
    output logic [LEN_WIDTH-1:0]          beat_count_o
);

    localparam int unsigned SELS_W = NUM_BUF * SEL_WIDTH;
    localparam int unsigned BUFD_W = NUM_BUF * DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    state_e                   state_q,    state_d;
    logic [SELS_W-1:0]        sel_q,      sel_d;
    logic [LEN_WIDTH-1:0]     len_q,      len_d;
    logic [HOLDOFF_WIDTH-1:0] holdoff_q,  holdoff_d;
    logic [HOLDOFF_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [LEN_WIDTH-1:0]     beat_cnt_q, beat_cnt_d;
    logic [BUFD_W-1:0]        tdata_q,    tdata_d;
    logic [NUM_BUF-1:0]       tvalid_q,   tvalid_d;
    logic                     armed_q,    armed_d;
    logic                     busy_q,     busy_d;
    logic                     done_q,     done_d;
    logic                     overflow_q, overflow_d;
`ifdef CAPTURE_TLAST_EN
    logic [NUM_BUF-1:0]       tlast_q,    tlast_d;
`endif

    logic [DATA_WIDTH-1:0]    adc_data_c [NUM_ADC];
    logic [NUM_BUF-1:0]       sel_valid_c;
    logic [BUFD_W-1:0]        sel_data_c;
    logic                     beat_c;
    logic                     last_beat_c;
    logic                     trig_c;

    // The ADCs are never backpressured.
    assign s_adc_tready = {NUM_ADC{1'b1}};

    // Split the flat ADC data bus into per-channel words.
    for (genvar a = 0; a < NUM_ADC; a++) begin : g_adc
        assign adc_data_c[a] = s_adc_tdata[a*DATA_WIDTH +: DATA_WIDTH];
    end

    // Per-buffer channel mux, driven from the configuration latched at arm.
    for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
        logic [SEL_WIDTH-1:0] sel_b;
        assign sel_b                                 = sel_q[b*SEL_WIDTH +: SEL_WIDTH];
        assign sel_valid_c[b]                        = s_adc_tvalid[sel_b];
        assign sel_data_c[b*DATA_WIDTH +: DATA_WIDTH] = adc_data_c[sel_b];
    end

    // A beat needs every selected channel valid, so the buffers stay aligned.
    assign beat_c      = &sel_valid_c;
    assign last_beat_c = (LEN_WIDTH'(beat_cnt_q + LEN_WIDTH'(1)) == len_q);
    assign trig_c      = trig_i | sw_trig_i;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        len_d      = len_q;
        holdoff_d  = holdoff_q;
        hold_cnt_d = hold_cnt_q;
        beat_cnt_d = beat_cnt_q;
        tdata_d    = tdata_q;
        tvalid_d   = '0;
        done_d     = done_q;
        // A valid beat with its buffer not ready is lost.
        overflow_d = overflow_q | (|(tvalid_q & ~m_buf_tready));
`ifdef CAPTURE_TLAST_EN
        tlast_d    = '0;
`endif

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_i && (len_i != '0)) begin
                        sel_d      = sel_i;
                        len_d      = len_i;
                        holdoff_d  = holdoff_i;
                        done_d     = 1'b0;
                        overflow_d = 1'b0;
                        beat_cnt_d = '0;
                        state_d    = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_c) begin
                        if (holdoff_q == '0) begin
                            state_d = ST_CAPTURE;
                        end else begin
                            hold_cnt_d = holdoff_q;
                            state_d    = ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_q <= HOLDOFF_WIDTH'(1)) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLDOFF_WIDTH'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (beat_c) begin
                        tdata_d  = sel_data_c;
                        tvalid_d = '1;
                        if (beat_cnt_q != len_q) begin
                            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                        end
                        if (last_beat_c) begin
                            state_d = ST_DONE;
`ifdef CAPTURE_TLAST_EN
                            tlast_d = '1;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        armed_d = (state_d == ST_ARMED);
        busy_d  = (state_d == ST_HOLDOFF) || (state_d == ST_CAPTURE);
    end

    // State and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            len_q      <= '0;
            holdoff_q  <= '0;
            hold_cnt_q <= '0;
            beat_cnt_q <= '0;
            tdata_q    <= '0;
            tvalid_q   <= '0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef CAPTURE_TLAST_EN
            tlast_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            len_q      <= len_d;
            holdoff_q  <= holdoff_d;
            hold_cnt_q <= hold_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
`ifdef CAPTURE_TLAST_EN
            tlast_q    <= tlast_d;
`endif
        end
    end

    assign m_buf_tdata  = tdata_q;
    assign m_buf_tvalid = tvalid_q;
    assign armed_o      = armed_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;
    assign beat_count_o = beat_cnt_q;
`ifdef CAPTURE_TLAST_EN
    assign m_buf_tlast  = tlast_q;
`endif

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_sequencer
//
// Self-checking bench for adc_capture_sequencer. Inputs change on the falling
// edge and outputs are sampled there too. Each ADC word encodes its channel and
// a stimulus sequence number. When the bench drives a cycle that must be a
// beat, it pushes the expected buffer payload, and pops it when the matching
// tvalid shows up. Covers the optional CAPTURE_TLAST_EN port when defined.
// ---------------------------------------------------------------------------
module tb_adc_capture_sequencer;

    localparam int unsigned NA = 8;
    localparam int unsigned NB = 4;
    localparam int unsigned DW = 128;
    localparam int unsigned LW = 16;
    localparam int unsigned HW = 16;

    // Capture scenarios: holdoff, length, trigger source, select, idle valid
    // mask, gap start (-1 = none) and valid mask during the 3-cycle gap.
    localparam int NCFG = 4;
    localparam int          CFG_H    [NCFG] = '{0, 10, 0, 0};
    localparam int          CFG_LEN  [NCFG] = '{4, 2, 8, 1};
    localparam int          CFG_SW   [NCFG] = '{0, 1, 0, 0};
    localparam logic [11:0] CFG_SEL  [NCFG] = '{12'h688, 12'hFAC, 12'h688, 12'h000};
    localparam logic [7:0]  CFG_VM   [NCFG] = '{8'hFF, 8'hF0, 8'h7F, 8'h01};
    localparam int          CFG_GAP  [NCFG] = '{-1, -1, 3, -1};
    localparam logic [7:0]  CFG_GVM  [NCFG] = '{8'hFF, 8'hFF, 8'h7D, 8'hFF};

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              arm_i, trig_i, sw_trig_i, abort_i;
    logic [NB*3-1:0]   sel_i;
    logic [LW-1:0]     len_i;
    logic [HW-1:0]     holdoff_i;
    logic [NA*DW-1:0]  adc_data;
    logic [NA-1:0]     adc_valid;
    logic [NA-1:0]     adc_ready;
    logic [NB*DW-1:0]  m_buf_tdata;
    logic [NB-1:0]     m_buf_tvalid;
    logic [NB-1:0]     m_buf_tready;
`ifdef CAPTURE_TLAST_EN
    logic [NB-1:0]     m_buf_tlast;
`endif
    logic              armed_o, busy_o, done_o, overflow_o;
    logic [LW-1:0]     beat_count_o;

    int                checks = 0;
    int                errors = 0;
    int unsigned       seq    = 0;
    logic [NB*DW-1:0]  exp_q [$];

    always #5 aclk = ~aclk;

    adc_capture_sequencer dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .arm_i        (arm_i),
        .trig_i       (trig_i),
        .sw_trig_i    (sw_trig_i),
        .abort_i      (abort_i),
        .sel_i        (sel_i),
        .len_i        (len_i),
        .holdoff_i    (holdoff_i),
        .s_adc_tdata  (adc_data),
        .s_adc_tvalid (adc_valid),
        .s_adc_tready (adc_ready),
        .m_buf_tdata  (m_buf_tdata),
        .m_buf_tvalid (m_buf_tvalid),
        .m_buf_tready (m_buf_tready),
`ifdef CAPTURE_TLAST_EN
        .m_buf_tlast  (m_buf_tlast),
`endif
        .armed_o      (armed_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o),
        .beat_count_o (beat_count_o)
    );

    function automatic logic [DW-1:0] adc_word(input int ch, input int unsigned s);
        return {32'hC0DE_0000 + 32'(ch), 32'h0, 32'(s), 32'(s) ^ 32'h5A5A_5A5A};
    endfunction

    function automatic logic [NB*DW-1:0] exp_bufs(input logic [11:0] sel, input int unsigned s);
        logic [NB*DW-1:0] e;
        e = '0;
        for (int b = 0; b < int'(NB); b++) e[b*DW +: DW] = adc_word(int'(sel[b*3 +: 3]), s);
        return e;
    endfunction

    // Present a fresh, uniquely tagged word on every ADC channel.
    task automatic drive_adc(input logic [NA-1:0] vmask);
        seq++;
        for (int ch = 0; ch < int'(NA); ch++) adc_data[ch*DW +: DW] = adc_word(ch, seq);
        adc_valid = vmask;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (m_buf_tvalid !== '0 || m_buf_tdata !== '0 || armed_o !== 1'b0 || busy_o !== 1'b0 ||
            done_o !== 1'b0 || overflow_o !== 1'b0 || beat_count_o !== '0) begin
            errors++;
            $display("FAIL reset_hold outputs got tv=%b ar=%b bz=%b dn=%b ov=%b bc=%0d exp all zero",
                     m_buf_tvalid, armed_o, busy_o, done_o, overflow_o, beat_count_o);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (adc_ready !== '1) begin
            errors++;
            $display("FAIL reset_tready got %b exp %b", adc_ready, 8'hFF);
        end
        checks++;
        if (m_buf_tvalid !== '0 || armed_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
            beat_count_o !== '0) begin
            errors++;
            $display("FAIL reset_release got tv=%b ar=%b bz=%b dn=%b bc=%0d exp idle zero",
                     m_buf_tvalid, armed_o, busy_o, done_o, beat_count_o);
        end
    endtask

    task automatic test_capture();
        int         npush, last_push, h, len, gs;
        logic       prev_push, push_now, gap, exp_busy, exp_done;
        logic [NB*DW-1:0] e;
        for (int k = 0; k < NCFG; k++) begin
            h = CFG_H[k];
            len = CFG_LEN[k];
            gs = CFG_GAP[k];
            @(negedge aclk);
            sel_i = CFG_SEL[k];
            len_i = LW'(len);
            holdoff_i = HW'(h);
            arm_i = 1'b1;
            drive_adc(CFG_VM[k]);
            @(negedge aclk);
            arm_i = 1'b0;
            checks++;
            if (armed_o !== 1'b1 || done_o !== 1'b0 || beat_count_o !== '0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL cap%0d_arm got ar=%b dn=%b bc=%0d bz=%b exp 1 0 0 0",
                         k, armed_o, done_o, beat_count_o, busy_o);
            end
            if (CFG_SW[k] != 0) sw_trig_i = 1'b1;
            else trig_i = 1'b1;
            drive_adc(CFG_VM[k]);
            npush = 0;
            last_push = -10;
            prev_push = 1'b0;
            for (int c = 0; c < h + len + 8; c++) begin
                @(negedge aclk);
                trig_i = 1'b0;
                sw_trig_i = 1'b0;
                exp_busy = (npush < len);
                exp_done = (npush == len) && (c >= last_push + 2);
                checks++;
                if (m_buf_tvalid !== {NB{prev_push}}) begin
                    errors++;
                    $display("FAIL cap%0d_tvalid c=%0d got %b exp %b", k, c, m_buf_tvalid, {NB{prev_push}});
                end
                if (prev_push) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (m_buf_tdata !== e) begin
                        errors++;
                        $display("FAIL cap%0d_tdata c=%0d got %h exp %h", k, c, m_buf_tdata, e);
                    end
                end
                checks++;
                if (busy_o !== exp_busy || done_o !== exp_done || beat_count_o !== LW'(npush)) begin
                    errors++;
                    $display("FAIL cap%0d_status c=%0d got bz=%b dn=%b bc=%0d exp bz=%b dn=%b bc=%0d",
                             k, c, busy_o, done_o, beat_count_o, exp_busy, exp_done, npush);
                end
`ifdef CAPTURE_TLAST_EN
                checks++;
                if (m_buf_tlast !== {NB{prev_push && (npush == len)}}) begin
                    errors++;
                    $display("FAIL cap%0d_tlast c=%0d got %b exp %b", k, c, m_buf_tlast,
                             {NB{prev_push && (npush == len)}});
                end
`endif
                gap = (gs >= 0) && (c >= gs) && (c < gs + 3);
                push_now = (c >= h) && (npush < len) && !gap;
                drive_adc(gap ? CFG_GVM[k] : CFG_VM[k]);
                if (push_now) begin
                    exp_q.push_back(exp_bufs(CFG_SEL[k], seq));
                    npush++;
                    last_push = c;
                end
                prev_push = push_now;
            end
            checks++;
            if (beat_count_o !== LW'(len) || exp_q.size() != 0) begin
                errors++;
                $display("FAIL cap%0d_end got bc=%0d pending=%0d exp bc=%0d pending=0",
                         k, beat_count_o, exp_q.size(), len);
            end
            exp_q.delete();
        end
    endtask

    task automatic test_overflow();
        @(negedge aclk);
        sel_i = 12'h688; len_i = LW'(4); holdoff_i = '0; arm_i = 1'b1;
        drive_adc('1);
        @(negedge aclk);
        arm_i = 1'b0; trig_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge aclk);
            trig_i = 1'b0;
            checks++;
            if (overflow_o !== (c >= 3)) begin
                errors++;
                $display("FAIL ovf_flag c=%0d got %b exp %b", c, overflow_o, (c >= 3));
            end
            m_buf_tready = (c == 2) ? 4'b1011 : 4'b1111;
            drive_adc('1);
        end
        m_buf_tready = '1;
        checks++;
        if (beat_count_o !== LW'(4) || done_o !== 1'b1 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_end got bc=%0d dn=%b ov=%b exp 4 1 1", beat_count_o, done_o, overflow_o);
        end
        len_i = LW'(2); arm_i = 1'b1;
        @(negedge aclk);
        arm_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0 || done_o !== 1'b0 || beat_count_o !== '0 || armed_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_rearm got ov=%b dn=%b bc=%0d ar=%b exp 0 0 0 1",
                     overflow_o, done_o, beat_count_o, armed_o);
        end
        abort_i = 1'b1;
        @(negedge aclk);
        abort_i = 1'b0;
        checks++;
        if (armed_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_abort_armed got ar=%b exp 0", armed_o);
        end
    endtask

    task automatic test_abort();
        // Abort while in holdoff.
        @(negedge aclk);
        sel_i = 12'h688; len_i = LW'(5); holdoff_i = HW'(10); arm_i = 1'b1;
        drive_adc('1);
        @(negedge aclk);
        arm_i = 1'b0; trig_i = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            trig_i = 1'b0;
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold_busy got %b exp 1", busy_o);
        end
        abort_i = 1'b1;
        @(negedge aclk);
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || armed_o !== 1'b0 || m_buf_tvalid !== '0 || done_o !== 1'b0 ||
            beat_count_o !== '0) begin
            errors++;
            $display("FAIL abort_hold got bz=%b ar=%b tv=%b dn=%b bc=%0d exp 0 0 0 0 0",
                     busy_o, armed_o, m_buf_tvalid, done_o, beat_count_o);
        end
        trig_i = 1'b1;
        @(negedge aclk);
        trig_i = 1'b0;
        @(negedge aclk);
        checks++;
        if (busy_o !== 1'b0 || armed_o !== 1'b0 || m_buf_tvalid !== '0) begin
            errors++;
            $display("FAIL idle_trig got bz=%b ar=%b tv=%b exp 0 0 0", busy_o, armed_o, m_buf_tvalid);
        end

        // Abort after three beats of a ten-beat capture.
        len_i = LW'(10); holdoff_i = '0; arm_i = 1'b1;
        @(negedge aclk);
        arm_i = 1'b0; trig_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            trig_i = 1'b0;
            drive_adc('1);
        end
        checks++;
        if (m_buf_tvalid !== '1 || beat_count_o !== LW'(3)) begin
            errors++;
            $display("FAIL abort_cap_pre got tv=%b bc=%0d exp 1111 3", m_buf_tvalid, beat_count_o);
        end
        abort_i = 1'b1;
        @(negedge aclk);
        abort_i = 1'b0;
        drive_adc('1);
        checks++;
        if (m_buf_tvalid !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || beat_count_o !== LW'(3)) begin
            errors++;
            $display("FAIL abort_cap got tv=%b bz=%b dn=%b bc=%0d exp 0000 0 0 3",
                     m_buf_tvalid, busy_o, done_o, beat_count_o);
        end

        // Zero-length arm is ignored and leaves the flags alone.
        len_i = '0; arm_i = 1'b1;
        @(negedge aclk);
        arm_i = 1'b0;
        @(negedge aclk);
        checks++;
        if (armed_o !== 1'b0 || busy_o !== 1'b0 || beat_count_o !== LW'(3) || done_o !== 1'b0) begin
            errors++;
            $display("FAIL arm_len0 got ar=%b bz=%b bc=%0d dn=%b exp 0 0 3 0",
                     armed_o, busy_o, beat_count_o, done_o);
        end

        // Arm and trigger in the same IDLE cycle only arms.
        len_i = LW'(3); arm_i = 1'b1; trig_i = 1'b1;
        @(negedge aclk);
        arm_i = 1'b0; trig_i = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if (armed_o !== 1'b1 || busy_o !== 1'b0 || m_buf_tvalid !== '0) begin
            errors++;
            $display("FAIL arm_trig_same got ar=%b bz=%b tv=%b exp 1 0 0", armed_o, busy_o, m_buf_tvalid);
        end
        abort_i = 1'b1;
        @(negedge aclk);
        abort_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge aclk);
        sel_i = 12'h688; len_i = LW'(8); holdoff_i = '0; arm_i = 1'b1;
        drive_adc('1);
        @(negedge aclk);
        arm_i = 1'b0; trig_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            trig_i = 1'b0;
            drive_adc('1);
        end
        @(negedge aclk);
        checks++;
        if (m_buf_tvalid !== '1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre got tv=%b bz=%b exp 1111 1", m_buf_tvalid, busy_o);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (m_buf_tvalid !== '0 || m_buf_tdata !== '0 || busy_o !== 1'b0 || armed_o !== 1'b0 ||
            done_o !== 1'b0 || overflow_o !== 1'b0 || beat_count_o !== '0) begin
            errors++;
            $display("FAIL rst_mid got tv=%b bz=%b ar=%b dn=%b ov=%b bc=%0d exp all zero",
                     m_buf_tvalid, busy_o, armed_o, done_o, overflow_o, beat_count_o);
        end
`ifdef CAPTURE_TLAST_EN
        checks++;
        if (m_buf_tlast !== '0) begin
            errors++;
            $display("FAIL rst_mid_tlast got %b exp 0000", m_buf_tlast);
        end
`endif
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || m_buf_tvalid !== '0 || adc_ready !== '1) begin
            errors++;
            $display("FAIL rst_mid_after got dn=%b bz=%b tv=%b rdy=%b exp 0 0 0000 ff",
                     done_o, busy_o, m_buf_tvalid, adc_ready);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        arm_i = 1'b0; trig_i = 1'b0; sw_trig_i = 1'b0; abort_i = 1'b0;
        sel_i = '0; len_i = '0; holdoff_i = '0;
        adc_data = '0; adc_valid = '0;
        m_buf_tready = '1;
        test_reset();
        test_capture();
        test_overflow();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
